updown_counter_param: RTL and testbench

//   Parametrised synchronous up/down counter. It is the generalised successor to the 4-bit 74LS191 model.
//   - Adds configurable width, a programmable terminal value (modulo-N), and wrap or saturate mode.
//   - Adds synchronous reset and a registered wrap-event pulse.
//   - Used for address sequencing, loop counters and cascaded timing chains.
//   - Cascades by feeding RCO_n into the next stage's CTEN_n.
//

---
 rtl/updown_counter_param.sv | 74 +++++++
 tb/tb_updown_counter_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with modulo-N terminal,
// wrap/saturate mode, cascade carry and registered wrap pulse.
module updown_counter_param #(
   parameter int          WIDTH     = 8,
   parameter int unsigned MAX_VALUE = (2**WIDTH) - 1,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD_n,
   input  logic             CTEN_n,
   input  logic             DOWN_UP_n,
   output logic [WIDTH-1:0] Q,
   output logic             MAX_MIN,
   output logic             RCO_n,
   output logic             WRAP_P
);

   localparam logic [WIDTH-1:0] MAXV = MAX_VALUE[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] load_val;
   logic             at_max, at_min;

   assign at_max   = (q_q == MAXV);
   assign at_min   = (q_q == ZERO);
   assign load_val = (D > MAXV) ? MAXV : D;

   // Next-state: load beats count beats hold; terminal handling per mode
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (!LOAD_n) begin
         q_d = load_val;
      end else if (!CTEN_n) begin
         if (!DOWN_UP_n) begin
            if (!at_max) begin
               q_d = q_q + ONE;
            end else if (!SATURATE) begin
               q_d    = ZERO;
               wrap_d = 1'b1;
            end
         end else begin
            if (!at_min) begin
               q_d = q_q - ONE;
            end else if (!SATURATE) begin
               q_d    = MAXV;
               wrap_d = 1'b1;
            end
         end
      end
   end

   // State register; synchronous reset overrides load and count
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         q_q    <= ZERO;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign Q       = q_q;
   assign WRAP_P  = wrap_q;
   assign MAX_MIN = DOWN_UP_n ? at_min : at_max;
   assign RCO_n   = ~(MAX_MIN & ~CTEN_n);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param: vector table,
// corner sequences, randomized model compare and a cascade chain.
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst_n, load_n, cten_n, dn;
   logic [3:0] d;

   logic [3:0] q0, q1, q2;
   logic       mm0, mm1, mm2, rco0, rco1, rco2, w0, w1, w2;

   logic       c_rst_n, c_load_n, c_en_n;
   logic [3:0] c_d, qlo, qhi;
   logic       mmlo, mmhi, rcolo, rcohi, wlo, whi;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // u0: 4-bit wrap, u1: decade wrap, u2: 4-bit saturate
   updown_counter_param #(.WIDTH(4)) u0 (
      .CLK(clk), .RESET_n(rst_n), .D(d), .LOAD_n(load_n),
      .CTEN_n(cten_n), .DOWN_UP_n(dn), .Q(q0), .MAX_MIN(mm0),
      .RCO_n(rco0), .WRAP_P(w0));

   updown_counter_param #(.WIDTH(4), .MAX_VALUE(9)) u1 (
      .CLK(clk), .RESET_n(rst_n), .D(d), .LOAD_n(load_n),
      .CTEN_n(cten_n), .DOWN_UP_n(dn), .Q(q1), .MAX_MIN(mm1),
      .RCO_n(rco1), .WRAP_P(w1));

   updown_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u2 (
      .CLK(clk), .RESET_n(rst_n), .D(d), .LOAD_n(load_n),
      .CTEN_n(cten_n), .DOWN_UP_n(dn), .Q(q2), .MAX_MIN(mm2),
      .RCO_n(rco2), .WRAP_P(w2));

   updown_counter_param #(.WIDTH(4)) ulo (
      .CLK(clk), .RESET_n(c_rst_n), .D(c_d), .LOAD_n(c_load_n),
      .CTEN_n(c_en_n), .DOWN_UP_n(1'b0), .Q(qlo), .MAX_MIN(mmlo),
      .RCO_n(rcolo), .WRAP_P(wlo));

   updown_counter_param #(.WIDTH(4)) uhi (
      .CLK(clk), .RESET_n(c_rst_n), .D(c_d), .LOAD_n(c_load_n),
      .CTEN_n(rcolo), .DOWN_UP_n(1'b0), .Q(qhi), .MAX_MIN(mmhi),
      .RCO_n(rcohi), .WRAP_P(whi));

   typedef struct {
      logic       rst_n, load_n, cten_n, dn;
      logic [3:0] d;
      int         q, mm, rco, w;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic l, input logic c,
                        input logic dr, input logic [3:0] dv);
      rst_n  = r;
      load_n = l;
      cten_n = c;
      dn     = dr;
      d      = dv;
   endtask

   // Reference: counter of range 0..mx, arithmetic modulo mx+1
   function automatic void model(input int q, input int mx, input int sat,
                                 input int r, input int l, input int c,
                                 input int dr, input int dv,
                                 output int nq, output int nw);
      nw = 0;
      nq = q;
      if (r == 0) nq = 0;
      else if (l == 0) nq = (dv > mx) ? mx : dv;
      else if (c == 0) begin
         if (dr == 0) begin
            if (sat != 0) nq = (q + 1 > mx) ? mx : q + 1;
            else begin
               nq = (q + 1) % (mx + 1);
               nw = (q == mx) ? 1 : 0;
            end
         end else begin
            if (sat != 0) nq = (q == 0) ? 0 : q - 1;
            else begin
               nq = (q + mx) % (mx + 1);
               nw = (q == 0) ? 1 : 0;
            end
         end
      end
   endfunction

   initial begin
      int mq[3];
      int mw[3];
      int mx[3];
      int ms[3];
      int nq, nw, mmx, rcx;
      int aq[3];
      int aw[3];
      int am[3];
      int ar[3];

      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      c_rst_n  = 1'b0;
      c_load_n = 1'b1;
      c_en_n   = 1'b1;
      c_d      = 4'd0;

      //            rst ld ct dn d     q  mm rco w
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  0, 0, 1, 0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 13, 0, 1, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  14, 0, 1, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  15, 1, 0, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0,  0, 1, 1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1,  0, 1, 0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  2,  0, 1, 0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  1,  0, 1, 0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  0,  1, 0, 0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  15, 0, 1, 1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  15, 1, 1, 0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  15, 1, 1, 0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  15, 1, 1, 0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  0,  0, 1, 0};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  0,  1, 1, 0};

      #2;
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rst_n, tbl[i].load_n, tbl[i].cten_n,
               tbl[i].dn, tbl[i].d);
         step();
         chk($sformatf("tbl%0d_q", i), int'(q0), tbl[i].q);
         chk($sformatf("tbl%0d_wrap", i), int'(w0), tbl[i].w);
         chk($sformatf("tbl%0d_maxmin", i), int'(mm0), tbl[i].mm);
         chk($sformatf("tbl%0d_rco", i), int'(rco0), tbl[i].rco);
      end

      // Combinational flag follows direction with no clock
      dn = 1'b0;
      #1;
      chk("dir_up_maxmin", int'(mm0), 0);
      dn = 1'b1;
      cten_n = 1'b0;
      #1;
      chk("dir_dn_maxmin", int'(mm0), 1);
      chk("dir_dn_rco", int'(rco0), 0);

      // Decade: clamp, wrap up, wrap down
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      step();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd12);
      step();
      chk("dec_clamp_q", int'(q1), 9);
      chk("dec_clamp_wrap", int'(w1), 0);
      chk("dec_at9_maxmin", int'(mm1), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      step();
      chk("dec_up_q", int'(q1), 0);
      chk("dec_up_wrap", int'(w1), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
      step();
      chk("dec_dn_q", int'(q1), 9);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
      step();
      chk("dec_wrap_clear", int'(w1), 0);

      // Saturate: pin at 15 going up, at 0 going down
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd14);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("sat_up%0d_q", i), int'(q2), 15);
         chk($sformatf("sat_up%0d_wrap", i), int'(w2), 0);
      end
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("sat_dn%0d_q", i), int'(q2), 0);
         chk($sformatf("sat_dn%0d_wrap", i), int'(w2), 0);
      end

      // Randomized against the model, all three variants
      mx = '{15, 9, 15};
      ms = '{0, 0, 1};
      mq = '{0, 0, 0};
      mw = '{0, 0, 0};
      for (int i = 0; i < 400; i++) begin
         drive((i == 0) ? 1'b0 : ($urandom_range(15) != 0),
               ($urandom_range(7) != 0), ($urandom_range(3) == 0),
               1'($urandom_range(1)), 4'($urandom_range(15)));
         for (int k = 0; k < 3; k++) begin
            model(mq[k], mx[k], ms[k], int'(rst_n), int'(load_n),
                  int'(cten_n), int'(dn), int'(d), nq, nw);
            mq[k] = nq;
            mw[k] = nw;
         end
         step();
         aq = '{int'(q0), int'(q1), int'(q2)};
         aw = '{int'(w0), int'(w1), int'(w2)};
         am = '{int'(mm0), int'(mm1), int'(mm2)};
         ar = '{int'(rco0), int'(rco1), int'(rco2)};
         for (int k = 0; k < 3; k++) begin
            mmx = (dn ? (mq[k] == 0) : (mq[k] == mx[k])) ? 1 : 0;
            rcx = (mmx == 1 && cten_n == 1'b0) ? 0 : 1;
            chk($sformatf("rnd%0d_u%0d_q", i, k), aq[k], mq[k]);
            chk($sformatf("rnd%0d_u%0d_wrap", i, k), aw[k], mw[k]);
            chk($sformatf("rnd%0d_u%0d_maxmin", i, k), am[k], mmx);
            chk($sformatf("rnd%0d_u%0d_rco", i, k), ar[k], rcx);
         end
      end

      // Cascade: 8-bit value must step by one every edge
      c_rst_n = 1'b0;
      step();
      chk("casc_reset", int'({qhi, qlo}), 0);
      c_rst_n = 1'b1;
      c_en_n  = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         step();
         chk($sformatf("casc%0d", i), int'({qhi, qlo}), i % 256);
      end
      c_en_n = 1'b1;
      step();
      chk("casc_hold", int'({qhi, qlo}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
